// File: rtl/tomasulo_pkg.sv
//------------------------------------------------------------------------------
// Module      : tomasulo_pkg
// Description : Shared defaults, FSM state encoding and store-queue entry type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tomasulo_pkg;

  localparam int C_DEPTH_DEF  = 4;
  localparam int C_ADDR_W_DEF = 12;
  localparam int C_DATA_W_DEF = 32;
  localparam int C_TAG_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RETIRE = 2'd2
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic                    committed;
    logic [C_TAG_W_DEF-1:0]  tag;
    logic [C_ADDR_W_DEF-1:0] addr;
    logic [C_DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/store_fwd_match.sv
//------------------------------------------------------------------------------
// Module      : store_fwd_match
// Description : Finds the youngest valid queue entry whose address equals a load address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_fwd_match
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = C_DEPTH_DEF,
  parameter int ADDR_W = C_ADDR_W_DEF
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [DEPTH*ADDR_W-1:0]  i_addr,
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic [ADDR_W-1:0]        i_ld_addr,
  output logic                     o_hit,
  output logic [$clog2(DEPTH)-1:0] o_idx
);

  localparam int C_PTR_W = $clog2(DEPTH);

  // Walk oldest to youngest; a later match overrides, leaving the youngest.
  always_comb begin
    logic [C_PTR_W-1:0] w_idx;
    o_hit = 1'b0;
    o_idx = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + C_PTR_W'(k);
      if (i_valid[w_idx] && (i_addr[w_idx*ADDR_W +: ADDR_W] == i_ld_addr)) begin
        o_hit = 1'b1;
        o_idx = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_unit.sv
//------------------------------------------------------------------------------
// Module      : store_unit
// Description : In-order store queue with commit tracking, memory write FSM and load forwarding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_unit
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = C_DEPTH_DEF,
  parameter int ADDR_W = C_ADDR_W_DEF,
  parameter int DATA_W = C_DATA_W_DEF,
  parameter int TAG_W  = C_TAG_W_DEF
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [DATA_W-1:0]          iss_base,
  input  logic [ADDR_W-1:0]          iss_off,
  input  logic [DATA_W-1:0]          iss_data,
  input  logic [TAG_W-1:0]           iss_tag,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  output logic                       done_valid,
  output logic [TAG_W-1:0]           done_tag,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  entry_t             r_q [DEPTH];
  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;
  logic [C_CNT_W-1:0] r_count;
  state_t             r_state;
  state_t             w_state_nxt;

  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_iss_addr;
  logic               w_cm_hit;
  logic [C_PTR_W-1:0] w_cm_idx;
  entry_t             w_head_e;
  logic [DEPTH-1:0]         w_valid_vec;
  logic [DEPTH*ADDR_W-1:0]  w_addr_flat;
  logic               w_fwd_hit;
  logic [C_PTR_W-1:0] w_fwd_idx;
  logic               w_unused_base;

  // Effective address wraps within ADDR_W; the upper base bits never matter.
  assign w_iss_addr    = iss_base[ADDR_W-1:0] + iss_off;
  assign w_unused_base = ^iss_base[DATA_W-1:ADDR_W];

  assign iss_ready = (r_count < C_CNT_W'(DEPTH));
  assign count     = r_count;
  assign w_push    = iss_valid && iss_ready;
  assign w_pop     = (r_state == RETIRE);
  assign w_head_e  = r_q[r_head];

  // Oldest-first search so the earliest uncommitted matching store wins.
  always_comb begin
    logic [C_PTR_W-1:0] w_idx;
    w_cm_hit = 1'b0;
    w_cm_idx = '0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + C_PTR_W'(k);
      if (!w_cm_hit && r_q[w_idx].valid && !r_q[w_idx].committed &&
          (r_q[w_idx].tag == commit_tag)) begin
        w_cm_hit = 1'b1;
        w_cm_idx = w_idx;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (commit_valid && w_cm_hit) begin
        r_q[w_cm_idx].committed <= 1'b1;
      end
      if (w_pop) begin
        r_q[r_head].valid     <= 1'b0;
        r_q[r_head].committed <= 1'b0;
        r_head                <= r_head + 1'b1;
      end
      if (w_push) begin
        r_q[r_tail].valid     <= 1'b1;
        r_q[r_tail].committed <= commit_valid && !w_cm_hit && (commit_tag == iss_tag);
        r_q[r_tail].tag       <= iss_tag;
        r_q[r_tail].addr      <= w_iss_addr;
        r_q[r_tail].data      <= iss_data;
        r_tail                <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done_valid  = 1'b0;
    done_tag    = '0;
    case (r_state)
      IDLE: begin
        if (w_head_e.valid && w_head_e.committed) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_addr  = w_head_e.addr;
        mem_wdata = w_head_e.data;
        if (mem_ack) begin
          w_state_nxt = RETIRE;
        end
      end
      RETIRE: begin
        done_valid  = 1'b1;
        done_tag    = w_head_e.tag;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i]                   = r_q[i].valid;
      w_addr_flat[i*ADDR_W +: ADDR_W] = r_q[i].addr;
    end
  end

  store_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .i_valid   (w_valid_vec),
    .i_addr    (w_addr_flat),
    .i_head    (r_head),
    .i_ld_addr (ld_addr),
    .o_hit     (w_fwd_hit),
    .o_idx     (w_fwd_idx)
  );

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_hit ? r_q[w_fwd_idx].data : '0;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_store_unit
// Description : Directed self-checking bench for store_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_unit;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_base;
  logic [11:0] iss_off;
  logic [31:0] iss_data;
  logic [2:0]  iss_tag;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        done_valid;
  logic [2:0]  done_tag;
  logic [11:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk1 = ~clk1;

  store_unit u_dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_base     (iss_base),
    .iss_off      (iss_off),
    .iss_data     (iss_data),
    .iss_tag      (iss_tag),
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .done_valid   (done_valid),
    .done_tag     (done_tag),
    .ld_addr      (ld_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .count        (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_issue(input logic [31:0] b, input logic [11:0] o,
                          input logic [31:0] d, input logic [2:0] t);
    iss_valid = 1'b1;
    iss_base  = b;
    iss_off   = o;
    iss_data  = d;
    iss_tag   = t;
    @(posedge clk1);
    #1 iss_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [2:0] t);
    commit_valid = 1'b1;
    commit_tag   = t;
    @(posedge clk1);
    #1 commit_valid = 1'b0;
  endtask

  // Waits (bounded) for a write, checks it, acks after hold cycles, checks the done pulse.
  task automatic expect_write(input logic [2:0] tg, input logic [11:0] a,
                              input logic [31:0] d, input int hold);
    int n = 0;
    @(negedge clk1);
    while (!mem_req && n < 20) begin
      @(negedge clk1);
      n++;
    end
    check("req_seen", mem_req, 1);
    check("mem_addr", mem_addr, a);
    check("mem_wdata", mem_wdata, d);
    check("done_idle", done_valid, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, a);
      check("wdata_hold", mem_wdata, d);
    end
    mem_ack = 1'b1;
    @(posedge clk1);
    #1 mem_ack = 1'b0;
    check("done_valid", done_valid, 1);
    check("done_tag", done_tag, tg);
    check("req_drop", mem_req, 0);
    @(posedge clk1);
    #1;
    check("done_pulse", done_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    iss_valid    = 1'b0;
    iss_base     = '0;
    iss_off      = '0;
    iss_data     = '0;
    iss_tag      = '0;
    commit_valid = 1'b0;
    commit_tag   = '0;
    mem_ack      = 1'b0;
    ld_addr      = '0;

    // Reset state
    #12;
    check("rst_count", count, 0);
    check("rst_req", mem_req, 0);
    check("rst_done", done_valid, 0);
    check("rst_fwd", fwd_hit, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    check("ready_after_rst", iss_ready, 1);

    // Basic store with ack after 3 cycles in WRITE
    do_issue(32'h10, 12'h004, 32'hDEADBEEF, 3'd2);
    check("basic_count1", count, 1);
    do_commit(3'd2);
    expect_write(3'd2, 12'h014, 32'hDEADBEEF, 2);
    check("basic_count0", count, 0);

    // In-order blocking: younger committed store waits for older uncommitted head
    do_issue(32'h100, 12'h000, 32'h11, 3'd1);
    do_issue(32'h100, 12'h004, 32'h44, 3'd4);
    do_commit(3'd4);
    repeat (3) @(negedge clk1);
    check("block_noreq", mem_req, 0);
    @(posedge clk1);
    #1;
    do_commit(3'd1);
    expect_write(3'd1, 12'h100, 32'h11, 0);
    expect_write(3'd4, 12'h104, 32'h44, 0);

    // Full queue, held 5th issue, drain with pointer wrap
    for (int i = 0; i < 4; i++) begin
      do_issue(32'h200, 12'(4 * i), 32'hA0 + i, 3'(i));
    end
    check("full_count", count, 4);
    check("full_ready", iss_ready, 0);
    do_issue(32'h240, 12'h000, 32'hFF, 3'd5);
    check("full_held", count, 4);
    for (int i = 0; i < 4; i++) begin
      do_commit(3'(i));
    end
    for (int i = 0; i < 4; i++) begin
      expect_write(3'(i), 12'h200 + 12'(4 * i), 32'hA0 + i, 0);
    end
    check("drain_count", count, 0);
    check("drain_ready", iss_ready, 1);

    // Issue committed in its own enqueue cycle
    commit_valid = 1'b1;
    commit_tag   = 3'd7;
    do_issue(32'h250, 12'h000, 32'h77, 3'd7);
    commit_valid = 1'b0;
    check("wrap_accept", count, 1);
    expect_write(3'd7, 12'h250, 32'h77, 0);

    // Forwarding: youngest match, no match, popped entry excluded
    do_issue(32'h20, 12'h000, 32'h1, 3'd1);
    do_issue(32'h20, 12'h000, 32'h2, 3'd2);
    ld_addr = 12'h020;
    #1;
    check("fwd_hit", fwd_hit, 1);
    check("fwd_young", fwd_data, 32'h2);
    ld_addr = 12'h024;
    #1;
    check("fwd_miss", fwd_hit, 0);
    check("fwd_miss_data", fwd_data, 0);
    do_issue(32'h20, 12'h004, 32'h3, 3'd3);
    check("fwd_hit24", fwd_data, 32'h3);
    do_commit(3'd1);
    expect_write(3'd1, 12'h020, 32'h1, 0);
    ld_addr = 12'h020;
    #1;
    check("fwd_after_pop1", fwd_data, 32'h2);
    do_commit(3'd2);
    expect_write(3'd2, 12'h020, 32'h2, 0);
    check("fwd_popped", fwd_hit, 0);
    do_commit(3'd3);
    expect_write(3'd3, 12'h024, 32'h3, 0);

    // Address wrap
    do_issue(32'hFFF, 12'h002, 32'h5A, 3'd6);
    do_commit(3'd6);
    expect_write(3'd6, 12'h001, 32'h5A, 0);

    // Reset mid-write, later ack ignored
    do_issue(32'h300, 12'h000, 32'h99, 3'd5);
    do_commit(3'd5);
    repeat (2) @(negedge clk1);
    check("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_addr", mem_addr, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk1);
      #1;
      check("late_ack_done", done_valid, 0);
      check("late_ack_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    check("end_count", count, 0);
    check("end_ready", iss_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
